// File: rtl/cluster_axi_stub.sv
// AXI-style slave stub for a cluster port: absorbs writes, answers reads with address-pattern data.
// Optional decode errors outside the address window when CLUSTER_AXI_STUB_ERR_EN is defined.
module cluster_axi_stub #(
   parameter int unsigned          AddrWidth = 48,
   parameter int unsigned          DataWidth = 64,
   parameter int unsigned          IdWidth   = 4,
   parameter int unsigned          MaxReads  = 4,
   parameter logic [AddrWidth-1:0] BaseAddr  = '0,
   parameter logic [AddrWidth-1:0] AddrSize  = AddrWidth'(32'h4_0000)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 aw_valid_i,
   output logic                 aw_ready_o,
   input  logic [IdWidth-1:0]   aw_id_i,
   input  logic [AddrWidth-1:0] aw_addr_i,
   input  logic [7:0]           aw_len_i,
   input  logic                 w_valid_i,
   output logic                 w_ready_o,
   input  logic                 w_last_i,
   output logic                 b_valid_o,
   input  logic                 b_ready_i,
   output logic [IdWidth-1:0]   b_id_o,
   output logic [1:0]           b_resp_o,
   input  logic                 ar_valid_i,
   output logic                 ar_ready_o,
   input  logic [IdWidth-1:0]   ar_id_i,
   input  logic [AddrWidth-1:0] ar_addr_i,
   input  logic [7:0]           ar_len_i,
   output logic                 r_valid_o,
   input  logic                 r_ready_i,
   output logic [IdWidth-1:0]   r_id_o,
   output logic [DataWidth-1:0] r_data_o,
   output logic [1:0]           r_resp_o,
   output logic                 r_last_o,
   output logic [15:0]          txn_cnt_o
);

`ifdef CLUSTER_AXI_STUB_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   localparam int unsigned PtrW      = (MaxReads > 1) ? $clog2(MaxReads) : 1;
   localparam int unsigned CntW      = $clog2(MaxReads + 1);
   localparam int unsigned BeatBytes = DataWidth / 8;

   // Window check is done one bit wider so BaseAddr+AddrSize cannot wrap.
   function automatic logic [1:0] decode_resp(input logic [AddrWidth-1:0] addr);
      logic [AddrWidth:0] a, lo, hi;
      a  = {1'b0, addr};
      lo = {1'b0, BaseAddr};
      hi = lo + {1'b0, AddrSize};
      return (ErrEn && (a < lo || a >= hi)) ? 2'b11 : 2'b00;
   endfunction

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxReads - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Burst length is never checked; only w_last ends a write.
   logic unused_ok;
   assign unused_ok = ^aw_len_i;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   w_state_e w_state, w_state_nxt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) w_state <= W_IDLE;
      else         w_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = w_state;
      aw_ready_o  = 1'b0;
      w_ready_o   = 1'b0;
      b_valid_o   = 1'b0;
      case (w_state)
         W_IDLE: begin
            aw_ready_o = 1'b1;
            if (aw_valid_i) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            w_ready_o = 1'b1;
            if (w_valid_i && w_last_i) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            b_valid_o = 1'b1;
            if (b_ready_i) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         b_id_o   <= '0;
         b_resp_o <= 2'b00;
      end else if (aw_valid_i && aw_ready_o) begin
         b_id_o   <= aw_id_i;
         b_resp_o <= decode_resp(aw_addr_i);
      end
   end

   logic [IdWidth-1:0]   fifo_id   [MaxReads];
   logic [AddrWidth-1:0] fifo_addr [MaxReads];
   logic [7:0]           fifo_len  [MaxReads];
   logic [1:0]           fifo_resp [MaxReads];
   logic [PtrW-1:0]      wr_ptr, rd_ptr;
   logic [CntW-1:0]      count;
   logic                 push, pop, b_hs;

   assign ar_ready_o = (count != CntW'(MaxReads));
   assign push       = ar_valid_i && ar_ready_o;
   assign pop        = r_valid_o && r_ready_i && r_last_o;
   assign b_hs       = b_valid_o && b_ready_i;

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_id[wr_ptr]   <= ar_id_i;
         fifo_addr[wr_ptr] <= ar_addr_i;
         fifo_len[wr_ptr]  <= ar_len_i;
         fifo_resp[wr_ptr] <= decode_resp(ar_addr_i);
      end
   end

   // The head entry stays in the FIFO while its burst is in flight; it is popped on the last beat.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
      end
   end

   logic                 busy;
   logic [7:0]           beat, cur_len;
   logic [AddrWidth-1:0] cur_addr;

   assign r_valid_o = busy;
   assign r_last_o  = busy && (beat == cur_len);
   assign r_data_o  = DataWidth'(cur_addr);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy     <= 1'b0;
         beat     <= '0;
         cur_len  <= '0;
         cur_addr <= '0;
         r_id_o   <= '0;
         r_resp_o <= 2'b00;
      end else if (!busy) begin
         if (count != '0) begin
            busy     <= 1'b1;
            beat     <= '0;
            cur_len  <= fifo_len[rd_ptr];
            cur_addr <= fifo_addr[rd_ptr];
            r_id_o   <= fifo_id[rd_ptr];
            r_resp_o <= fifo_resp[rd_ptr];
         end
      end else if (r_ready_i) begin
         if (r_last_o) begin
            busy <= 1'b0;
         end else begin
            beat     <= beat + 8'd1;
            cur_addr <= cur_addr + AddrWidth'(BeatBytes);
         end
      end
   end

   logic [16:0] txn_sum;
   assign txn_sum = {1'b0, txn_cnt_o} + 17'(b_hs) + 17'(pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) txn_cnt_o <= '0;
      else         txn_cnt_o <= txn_sum[16] ? 16'hFFFF : txn_sum[15:0];
   end

endmodule

// File: tb/tb_cluster_axi_stub.sv
// Self-checking bench for cluster_axi_stub: random traffic against a transaction-level model.
module tb_cluster_axi_stub;

`ifdef CLUSTER_AXI_STUB_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
   logic [3:0]  aw_id, b_id, ar_id, r_id;
   logic [47:0] aw_addr, ar_addr;
   logic [7:0]  aw_len, ar_len;
   logic [1:0]  b_resp, r_resp;
   logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
   logic [63:0] r_data;
   logic [15:0] txn_cnt;

   always #5 clk = ~clk;

   cluster_axi_stub dut (
      .clk_i(clk), .rst_ni(rst_n),
      .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
      .aw_len_i(aw_len), .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
      .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
      .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
      .ar_len_i(ar_len), .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id),
      .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last), .txn_cnt_o(txn_cnt)
   );

   typedef logic [70:0] beat_t;   // {id, data, resp, last}
   typedef logic [5:0]  bresp_t;  // {id, resp}

   beat_t  exp_r[$], got_r[$];
   bresp_t exp_b[$], got_b[$];
   int     checks = 0, fails = 0, exp_txn = 0;
   int     r_unstable = 0, b_unstable = 0;
   bit     rand_rdy = 1'b0;
   beat_t  prev_r;
   bresp_t prev_b;
   logic   r_hold = 1'b0, b_hold = 1'b0;

   wire beat_t  r_now = {r_id, r_data, r_resp, r_last};
   wire bresp_t b_now = {b_id, b_resp};

   always @(posedge clk) begin
      if (!rst_n) begin
         r_hold <= 1'b0;
         b_hold <= 1'b0;
      end else begin
         if (r_hold && (!r_valid || r_now !== prev_r)) r_unstable <= r_unstable + 1;
         if (b_hold && (!b_valid || b_now !== prev_b)) b_unstable <= b_unstable + 1;
         if (r_valid && r_ready) got_r.push_back(r_now);
         if (b_valid && b_ready) got_b.push_back(b_now);
         r_hold <= r_valid && !r_ready;
         b_hold <= b_valid && !b_ready;
         prev_r <= r_now;
         prev_b <= b_now;
      end
   end

   function automatic logic [1:0] exp_resp(input logic [47:0] addr);
      return (ErrEn && addr >= 48'h4_0000) ? 2'b11 : 2'b00;
   endfunction

   task automatic tick();
      @(negedge clk);
      if (rand_rdy) begin
         r_ready = 1'($urandom_range(0, 1));
         b_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic do_ar(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len);
      int n;
      logic [47:0] a;
      n = 0;
      ar_id = id; ar_addr = addr; ar_len = len; ar_valid = 1'b1;
      while (!ar_ready && n < 500) begin tick(); n++; end
      if (n >= 500) begin
         checks++; fails++;
         $display("FAIL ar_accept id=%0d ar_ready=%b required 1", id, ar_ready);
      end else begin
         for (int k = 0; k <= int'(len); k++) begin
            a = addr + 48'(k * 8);
            exp_r.push_back({id, 16'h0, a, exp_resp(addr), k == int'(len)});
         end
         exp_txn++;
      end
      tick();
      ar_valid = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len);
      int n;
      n = 0;
      aw_id = id; aw_addr = addr; aw_len = len; aw_valid = 1'b1;
      while (!aw_ready && n < 500) begin tick(); n++; end
      if (n >= 500) begin
         checks++; fails++;
         $display("FAIL aw_accept id=%0d aw_ready=%b required 1", id, aw_ready);
      end
      tick();
      aw_valid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         if (rand_rdy && $urandom_range(0, 1) == 1) tick();
         w_valid = 1'b1; w_last = (b == int'(len));
         n = 0;
         while (!w_ready && n < 500) begin tick(); n++; end
         if (n >= 500) begin
            checks++; fails++;
            $display("FAIL w_accept beat=%0d w_ready=%b required 1", b, w_ready);
         end
         tick();
         w_valid = 1'b0; w_last = 1'b0;
      end
      exp_b.push_back({id, exp_resp(addr)});
      exp_txn++;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((got_r.size() < exp_r.size() || got_b.size() < exp_b.size()) && n < 3000) begin
         tick(); n++;
      end
      if (n >= 3000) begin
         checks++; fails++;
         $display("FAIL drain r=%0d/%0d b=%0d/%0d", got_r.size(), exp_r.size(), got_b.size(), exp_b.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; w_valid = 0; w_last = 0; b_ready = 0;
      ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; r_ready = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last} !== 6'b110000) begin
         fails++;
         $display("FAIL reset_ctrl got=%b required=110000",
                  {aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last});
      end
      checks++;
      if (txn_cnt !== 16'h0) begin fails++; $display("FAIL reset_txn got=%h required=0", txn_cnt); end
      checks++;
      if ({b_id, b_resp, r_id, r_data, r_resp} !== '0) begin
         fails++; $display("FAIL reset_payload got=%h required=0", {b_id, b_resp, r_id, r_data, r_resp});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      b_ready = 1'b1;
      aw_id = 4'd3; aw_addr = 48'h100; aw_len = 8'd1; aw_valid = 1'b1;
      tick();
      aw_valid = 1'b0;
      checks++;
      if ({aw_ready, w_ready, b_valid} !== 3'b010) begin
         fails++; $display("FAIL wdata_state got=%b required=010", {aw_ready, w_ready, b_valid});
      end
      w_valid = 1'b1; w_last = 1'b0;
      tick();
      w_last = 1'b1;
      tick();
      w_valid = 1'b0; w_last = 1'b0;
      checks++;
      if ({aw_ready, w_ready, b_valid, b_id, b_resp} !== {3'b001, 4'd3, 2'b00}) begin
         fails++; $display("FAIL bresp got=%b required=001001100", {aw_ready, w_ready, b_valid, b_id, b_resp});
      end
      exp_b.push_back({4'd3, 2'b00});
      exp_txn++;
      tick();
      checks++;
      if ({b_valid, txn_cnt} !== {1'b0, 16'd1}) begin
         fails++; $display("FAIL write_txn b_valid=%b txn=%0d required 0/1", b_valid, txn_cnt);
      end
   endtask

   task automatic test_read_basic();
      int base;
      beat_t want [3];
      base = got_r.size();
      want[0] = {4'd5, 64'h40, 2'b00, 1'b0};
      want[1] = {4'd5, 64'h48, 2'b00, 1'b0};
      want[2] = {4'd5, 64'h50, 2'b00, 1'b1};
      r_ready = 1'b1;
      do_ar(4'd5, 48'h40, 8'd2);
      wait_drain();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (base + i >= got_r.size() || got_r[base + i] !== want[i]) begin
            fails++;
            $display("FAIL read_basic[%0d] got=%h required=%h", i,
                     (base + i < got_r.size()) ? got_r[base + i] : 'x, want[i]);
         end
      end
      checks++;
      if (txn_cnt !== 16'(exp_txn)) begin fails++; $display("FAIL read_txn got=%0d required=%0d", txn_cnt, exp_txn); end
   endtask

   task automatic test_back_to_back();
      int base;
      base = exp_r.size();
      r_ready = 1'b0;
      for (int i = 0; i < 4; i++) do_ar(4'(i), 48'h1000 + 48'(i * 'h100), 8'(i));
      checks++;
      if ({ar_ready, r_valid} !== 2'b01) begin
         fails++; $display("FAIL fifo_full ar_ready/r_valid got=%b required=01", {ar_ready, r_valid});
      end
      r_ready = 1'b1;
      do_ar(4'd4, 48'h2000, 8'd1);
      wait_drain();
      for (int i = base; i < exp_r.size(); i++) begin
         checks++;
         if (i >= got_r.size() || got_r[i] !== exp_r[i]) begin
            fails++;
            $display("FAIL b2b_beat[%0d] got=%h required=%h", i - base, (i < got_r.size()) ? got_r[i] : 'x, exp_r[i]);
         end
      end
      checks++;
      if (txn_cnt !== 16'(exp_txn)) begin fails++; $display("FAIL b2b_txn got=%0d required=%0d", txn_cnt, exp_txn); end
   endtask

   task automatic test_stall();
      int base, n, unst0;
      base = exp_r.size();
      unst0 = r_unstable;
      r_ready = 1'b0;
      do_ar(4'd6, 48'h3000, 8'd7);
      n = 0;
      while (got_r.size() < exp_r.size() && n < 200) begin
         r_ready = ~r_ready;
         tick(); n++;
      end
      r_ready = 1'b1;
      wait_drain();
      for (int i = base; i < exp_r.size(); i++) begin
         checks++;
         if (i >= got_r.size() || got_r[i] !== exp_r[i]) begin
            fails++;
            $display("FAIL stall_beat[%0d] got=%h required=%h", i - base, (i < got_r.size()) ? got_r[i] : 'x, exp_r[i]);
         end
      end
      checks++;
      if (r_unstable !== unst0) begin fails++; $display("FAIL stall_stable changes=%0d required=0", r_unstable - unst0); end
   endtask

   task automatic test_random();
      int rbase, bbase;
      rbase = exp_r.size();
      bbase = exp_b.size();
      rand_rdy = 1'b1;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 1) == 1)
            do_write(4'($urandom), 48'($urandom_range(0, 'h7FFFF)), 8'($urandom_range(0, 3)));
         else
            do_ar(4'($urandom), 48'($urandom_range(0, 'h7FFFF)), 8'($urandom_range(0, 7)));
      end
      wait_drain();
      rand_rdy = 1'b0;
      r_ready = 1'b1; b_ready = 1'b1;
      tick();
      for (int i = rbase; i < exp_r.size(); i++) begin
         checks++;
         if (i >= got_r.size() || got_r[i] !== exp_r[i]) begin
            fails++;
            $display("FAIL rand_r[%0d] got=%h required=%h", i, (i < got_r.size()) ? got_r[i] : 'x, exp_r[i]);
         end
      end
      for (int i = bbase; i < exp_b.size(); i++) begin
         checks++;
         if (i >= got_b.size() || got_b[i] !== exp_b[i]) begin
            fails++;
            $display("FAIL rand_b[%0d] got=%h required=%h", i, (i < got_b.size()) ? got_b[i] : 'x, exp_b[i]);
         end
      end
      checks++;
      if ({got_r.size(), got_b.size()} !== {exp_r.size(), exp_b.size()}) begin
         fails++; $display("FAIL rand_count r=%0d/%0d b=%0d/%0d", got_r.size(), exp_r.size(), got_b.size(), exp_b.size());
      end
      checks++;
      if (txn_cnt !== 16'(exp_txn)) begin fails++; $display("FAIL rand_txn got=%0d required=%0d", txn_cnt, exp_txn); end
   endtask

`ifdef CLUSTER_AXI_STUB_ERR_EN
   task automatic test_err();
      int rb, bb;
      rb = got_r.size();
      bb = got_b.size();
      r_ready = 1'b1; b_ready = 1'b1;
      do_ar(4'd2, 48'h4_0000, 8'd0);
      do_write(4'd7, 48'h4_0000, 8'd0);
      do_write(4'd8, 48'h3_FFF8, 8'd0);
      wait_drain();
      checks++;
      if (rb >= got_r.size() || got_r[rb] !== {4'd2, 64'h4_0000, 2'b11, 1'b1}) begin
         fails++; $display("FAIL err_read got=%h required=%h", (rb < got_r.size()) ? got_r[rb] : 'x,
                           {4'd2, 64'h4_0000, 2'b11, 1'b1});
      end
      checks++;
      if (bb + 1 >= got_b.size() || {got_b[bb], got_b[bb + 1]} !== {4'd7, 2'b11, 4'd8, 2'b00}) begin
         fails++; $display("FAIL err_write got_count=%0d required decerr then okay", got_b.size() - bb);
      end
   endtask
`endif

   task automatic test_reset_midburst();
      int base, n;
      base = got_r.size();
      r_ready = 1'b1;
      do_ar(4'd9, 48'h300, 8'd3);
      n = 0;
      while (got_r.size() < base + 2 && n < 100) begin tick(); n++; end
      checks++;
      if (r_valid !== 1'b1) begin fails++; $display("FAIL midburst_active r_valid=%b required 1", r_valid); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({r_valid, r_last, txn_cnt} !== 18'h0) begin
         fails++; $display("FAIL midburst_abort r_valid=%b r_last=%b txn=%0d required 0", r_valid, r_last, txn_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      while (exp_r.size() > got_r.size()) void'(exp_r.pop_back());
      exp_txn = 0;
      checks++;
      if ({aw_ready, ar_ready} !== 2'b11) begin
         fails++; $display("FAIL post_reset_ready got=%b required=11", {aw_ready, ar_ready});
      end
      base = exp_r.size();
      do_ar(4'd1, 48'h80, 8'd0);
      wait_drain();
      checks++;
      if (base >= got_r.size() || got_r[base] !== {4'd1, 64'h80, 2'b00, 1'b1}) begin
         fails++; $display("FAIL post_reset_read got=%h required=%h", (base < got_r.size()) ? got_r[base] : 'x,
                           {4'd1, 64'h80, 2'b00, 1'b1});
      end
      checks++;
      if (txn_cnt !== 16'd1) begin fails++; $display("FAIL post_reset_txn got=%0d required=1", txn_cnt); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_basic();
      test_back_to_back();
      test_stall();
      test_random();
`ifdef CLUSTER_AXI_STUB_ERR_EN
      test_err();
`endif
      test_reset_midburst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cluster_axi_stub.md
CLUSTER_AXI_STUB -- requirements
Module: cluster_axi_stub

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, address width in bits.
REQ-002 SHALL have parameter DataWidth, default 64, read data width in bits; power of two, at least 8.
REQ-003 SHALL have parameter IdWidth, default 4, transaction ID width.
REQ-004 SHALL have parameter MaxReads, default 4, read-request FIFO depth; at least 1.
REQ-005 SHALL have parameters BaseAddr, default 0, and AddrSize, default 'h4_0000, which define the decoded window.
REQ-006 SHALL have these ports:
- clk_i  in  1  sole clock; all logic on its rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- aw_valid_i / aw_ready_o  in/out  1  write-address handshake.
- aw_id_i  in  IdWidth  write ID.
- aw_addr_i  in  AddrWidth  write start address.
- aw_len_i  in  8  write beats minus one.
- w_valid_i / w_ready_o  in/out  1  write-data handshake; data is discarded.
- w_last_i  in  1  final write beat.
- b_valid_o / b_ready_i  out/in  1  write-response handshake.
- b_id_o  out  IdWidth  response ID.
- b_resp_o  out  2  write response.
- ar_valid_i / ar_ready_o  in/out  1  read-address handshake.
- ar_id_i  in  IdWidth  read ID.
- ar_addr_i  in  AddrWidth  read start address.
- ar_len_i  in  8  read beats minus one.
- r_valid_o / r_ready_i  out/in  1  read-data handshake.
- r_id_o  out  IdWidth  read ID.
- r_data_o  out  DataWidth  read data.
- r_resp_o  out  2  read response.
- r_last_o  out  1  final read beat.
- txn_cnt_o  out  16  completed transactions, saturating.

Function
REQ-007 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
- W_IDLE: aw_ready_o=1. An AW handshake latches the ID and the response, then moves to W_DATA.
- W_DATA: w_ready_o=1. A handshake with w_last_i=1 moves to W_RESP. The aw_len_i beat count is not checked.
- W_RESP: b_valid_o=1 until b_ready_i is seen, then moves to W_IDLE.
REQ-008 Only one write SHALL be outstanding. aw_ready_o SHALL be 0 outside W_IDLE, and w_ready_o SHALL be 0 outside W_DATA.
REQ-009 An AR handshake SHALL push {id, addr, len, resp} into the FIFO. ar_ready_o SHALL equal "FIFO not full".
REQ-010 The read engine SHALL take the FIFO head whenever the head is non-empty and the engine is idle. This adds one cycle from AR handshake to first r_valid_o.
REQ-011 The read engine SHALL emit len+1 beats.
- Beat k carries r_data_o = zero-extended (addr + k*DataWidth/8), truncated to DataWidth.
- r_last_o=1 only on beat len.
- On a final-beat handshake the head SHALL be popped.
- The next head may start on the following cycle.
REQ-012 A simultaneous push to a full FIFO and pop SHALL NOT occur, since ready is computed from the registered full flag. A simultaneous push and pop on a non-full FIFO SHALL keep the occupancy unchanged.
REQ-013 Valid outputs and their payloads SHALL remain stable until the corresponding handshake completes.
REQ-014 txn_cnt_o SHALL increment by 1 per B handshake and per final R handshake.
- A B and a final R in the same cycle add 2.
- The count saturates at 'hFFFF.
REQ-015 Response encoding SHALL follow REQ-019. The write and read paths SHALL be independent.

Reset
REQ-016 While rst_ni=0, the block SHALL hold:
- write FSM in W_IDLE and FIFO empty;
- all valid outputs 0, aw_ready_o and ar_ready_o 1, w_ready_o 0;
- r_last_o 0, txn_cnt_o 0, all payload outputs 0.
REQ-017 Reset asserted mid-burst SHALL abort the burst immediately with no response. After deassertion the block SHALL resume accepting requests from the first cycle.

Configuration
REQ-018 Without CLUSTER_AXI_STUB_ERR_EN, every b_resp_o and r_resp_o SHALL be 2'b00 (OKAY).
REQ-019 With CLUSTER_AXI_STUB_ERR_EN defined, the response for each transaction SHALL be decided at its AW or AR handshake.
- Start address outside [BaseAddr, BaseAddr+AddrSize) gives 2'b11 (DECERR) on B or on every R beat.
- In-range start address gives 2'b00.
- Read data is unchanged.

Verification
REQ-020 AW(id=3, addr='h100, len=1), two W beats, b_ready=1 -> b_valid=1 with b_id=3 and b_resp=0; txn_cnt=1.
REQ-021 AR(id=5, addr='h40, len=2), r_ready=1 -> three beats with data 'h40, 'h48, 'h50, r_last only on the third, r_id=5.
REQ-022 Five back-to-back ARs with MaxReads=4 and r_ready=0 -> ar_ready=0 after the fourth; releasing r_ready drains all five in order.
REQ-023 r_ready toggling every cycle during an 8-beat read -> data and r_last stable while stalled; no beat lost or duplicated.
REQ-024 With CLUSTER_AXI_STUB_ERR_EN, AR addr='h4_0000, len=0 -> r_resp=2'b11 and r_last=1. Reset asserted during beat 2 of 4 -> r_valid=0 next cycle and txn_cnt=0.
